// File: rtl/entrada_switch_handshake_pkg.sv
// Shared definitions for the switch-input stage: data widths, FSM state type
// and the switch-word sign extension.
package sistema_pkg;

  localparam int LARGURA_DADO   = 32;
  localparam int LARGURA_SWITCH = 9;

  typedef enum logic [1:0] {
    OCIOSO,
    ESPERA_PRESSAO,
    ESPERA_SOLTURA
  } estado_entrada_t;

  function automatic logic [LARGURA_DADO-1:0] estenderSinal(input logic [LARGURA_SWITCH-1:0] valor);
    return {{(LARGURA_DADO - LARGURA_SWITCH){valor[LARGURA_SWITCH-1]}}, valor};
  endfunction

endpackage

// File: rtl/entrada_switch_handshake_if.sv
// Handshake and data bundle between the switch-input stage (slave) and the
// control unit / board pins (master).
interface entrada_switch_handshake_if;
  import sistema_pkg::*;

  logic                      enter;
  logic [LARGURA_SWITCH-1:0] entradaSwitch;
  logic                      pedido;
  logic [LARGURA_DADO-1:0]   dado;
  logic                      pronto;
  logic                      aguardando;

  modport master (
    output enter, entradaSwitch, pedido,
    input  dado, pronto, aguardando
  );

  modport slave (
    input  enter, entradaSwitch, pedido,
    output dado, pronto, aguardando
  );

endinterface

// File: rtl/entrada_switch_handshake_filtro_botao.sv
// Two-flop synchroniser plus debounce counter for the pushbutton.
// Only compiled when ENTRADA_SWITCH_DEBOUNCE_EN is defined.
`ifdef ENTRADA_SWITCH_DEBOUNCE_EN
module filtro_botao #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic bruto,
  output logic limpo
);

  localparam int LARGURA_CONT = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [LARGURA_CONT-1:0] CONT_FINAL = LARGURA_CONT'(DEBOUNCE_CYCLES - 1);
  localparam logic [LARGURA_CONT-1:0] UM = LARGURA_CONT'(1);

  logic                    sinc1;
  logic                    sinc2;
  logic [LARGURA_CONT-1:0] contagem;

  // The level is accepted on the edge where the N-th consecutive differing
  // sample is seen, so the counter only has to reach N-1 before that edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sinc1    <= 1'b0;
      sinc2    <= 1'b0;
      limpo    <= 1'b0;
      contagem <= '0;
    end else begin
      sinc1 <= bruto;
      sinc2 <= sinc1;
      if (sinc2 == limpo) begin
        contagem <= '0;
      end else if (contagem == CONT_FINAL) begin
        limpo    <= sinc2;
        contagem <= '0;
      end else begin
        contagem <= contagem + UM;
      end
    end
  end

endmodule
`endif

// File: rtl/entrada_switch_handshake.sv
// Switch-input stage: button conditioning, request/acknowledge FSM and capture
// of the sign-extended switch word. Debounce enabled by ENTRADA_SWITCH_DEBOUNCE_EN.
module entrada_switch_handshake
  import sistema_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                        clock,
  input logic                        reset,
  entrada_switch_handshake_if.slave  bus
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : gParamInvalido
    $error("DEBOUNCE_CYCLES must be within 1..255");
  end

  logic pressionado;
  logic pressionadoDb;
  logic pressionadoDbAnt;
  logic borda;

  assign pressionado = ~bus.enter;

`ifdef ENTRADA_SWITCH_DEBOUNCE_EN
  filtro_botao #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) uFiltro (
    .clock (clock),
    .reset (reset),
    .bruto (pressionado),
    .limpo (pressionadoDb)
  );
`else
  logic sinc1;
  logic sinc2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sinc1 <= 1'b0;
      sinc2 <= 1'b0;
    end else begin
      sinc1 <= pressionado;
      sinc2 <= sinc1;
    end
  end

  assign pressionadoDb = sinc2;
`endif

  assign borda = pressionadoDb & ~pressionadoDbAnt;

  // state          | meaning
  // OCIOSO         | no pending input instruction
  // ESPERA_PRESSAO | request pending, waiting for a fresh button press
  // ESPERA_SOLTURA | word captured, waiting for the button to be released
  estado_entrada_t         estado;
  estado_entrada_t         estadoProx;
  logic                    capturar;
  logic [LARGURA_DADO-1:0] dado;
  logic                    pronto;
  logic                    aguardando;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado           <= OCIOSO;
      pressionadoDbAnt <= 1'b0;
      dado             <= '0;
      pronto           <= 1'b0;
      aguardando       <= 1'b0;
    end else begin
      estado           <= estadoProx;
      pressionadoDbAnt <= pressionadoDb;
      pronto           <= capturar;
      aguardando       <= (estado == ESPERA_PRESSAO);
      if (capturar) begin
        dado <= estenderSinal(bus.entradaSwitch);
      end
    end
  end

  // pedido is deliberately ignored once the word is captured; only release exits.
  always_comb begin
    estadoProx = estado;
    capturar   = 1'b0;
    case (estado)
      OCIOSO: begin
        if (bus.pedido) estadoProx = ESPERA_PRESSAO;
      end
      ESPERA_PRESSAO: begin
        if (!bus.pedido) begin
          estadoProx = OCIOSO;
        end else if (borda) begin
          capturar   = 1'b1;
          estadoProx = ESPERA_SOLTURA;
        end
      end
      ESPERA_SOLTURA: begin
        if (!pressionadoDb) estadoProx = OCIOSO;
      end
      default: estadoProx = OCIOSO;
    endcase
  end

  assign bus.dado       = dado;
  assign bus.pronto     = pronto;
  assign bus.aguardando = aguardando;

endmodule

// File: tb/tb_entrada_switch_handshake.sv
// Directed bench for entrada_switch_handshake with a cycle-level reference model
// and hand-computed latency/data expectations.
module tb_entrada_switch_handshake;
  import sistema_pkg::*;

  localparam int N = 4;
`ifdef ENTRADA_SWITCH_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
  localparam int NEF = N;
`else
  localparam bit DEB = 1'b0;
  localparam int NEF = 0;
`endif
  // negedges from driving enter low (before e0) to the negedge that sees pronto
  localparam int LAT = NEF + 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  entrada_switch_handshake_if bus ();

  entrada_switch_handshake #(
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
    compared++;
    if (obtido !== esperado) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nome, obtido, esperado, $time);
    end
  endtask

  // Reference model: the button level is seen two samples late, accepted after
  // N consecutive disagreeing samples, and a capture needs a fresh rising level
  // while a request is pending. fase: 0 idle, 1 request pending, 2 held after capture.
  bit          mS1, mS2, mDb, mDbAnt, mPronto, mAguard, modelOk;
  int          mRun, mFase;
  logic [31:0] mDado;
  bit          dbNow, mBorda, prontoN, aguardN;
  int          faseN;

  initial modelOk = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      mS1 = 0; mS2 = 0; mDb = 0; mDbAnt = 0; mRun = 0; mFase = 0;
      mDado = '0; mPronto = 0; mAguard = 0; modelOk = 1'b1;
    end else begin
      dbNow   = DEB ? mDb : mS2;
      mBorda  = dbNow && !mDbAnt;
      aguardN = (mFase == 1);
      prontoN = 0;
      faseN   = mFase;
      if (mFase == 0) begin
        if (bus.pedido) faseN = 1;
      end else if (mFase == 1) begin
        if (!bus.pedido) faseN = 0;
        else if (mBorda) begin
          faseN   = 2;
          prontoN = 1;
          mDado   = 32'($signed(bus.entradaSwitch));
        end
      end else begin
        if (!dbNow) faseN = 0;
      end
      mDbAnt = dbNow;
      if (DEB) begin
        if (mS2 != mDb) begin
          mRun++;
          if (mRun >= N) begin
            mDb  = mS2;
            mRun = 0;
          end
        end else begin
          mRun = 0;
        end
      end
      mS2 = mS1;
      mS1 = !bus.enter;
      mFase   = faseN;
      mPronto = prontoN;
      mAguard = aguardN;
    end
  end

  always @(negedge clock) begin
    if (modelOk) begin
      check("model_pronto", 32'(bus.pronto), 32'(mPronto));
      check("model_aguardando", 32'(bus.aguardando), 32'(mAguard));
      check("model_dado", bus.dado, mDado);
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pressionar(output int lat);
    bit visto;
    visto = 0;
    lat = 0;
    bus.enter = 1'b0;
    while (!visto && lat < 80) begin
      @(negedge clock);
      lat++;
      if (bus.pronto) visto = 1;
    end
    if (!visto) check("pronto_timeout", 32'(lat), 32'(LAT));
  endtask

  task automatic contarPronto(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clock);
      if (bus.pronto) cnt++;
    end
  endtask

  logic [8:0]  tabSw  [4] = '{9'h005, 9'h1F6, 9'h1FF, 9'h0FF};
  logic [31:0] tabExp [4] = '{32'h0000_0005, 32'hFFFF_FFF6, 32'hFFFF_FFFF, 32'h0000_00FF};

  initial begin
    int lat, cnt;
    bus.enter = 1'b1;
    bus.pedido = 1'b0;
    bus.entradaSwitch = '0;
    ciclos(3);
    check("reset_dado", bus.dado, 32'h0);
    check("reset_pronto", 32'(bus.pronto), 32'h0);
    check("reset_aguardando", 32'(bus.aguardando), 32'h0);
    reset = 1'b0;
    ciclos(2);

    // basic capture and sign-extension boundaries
    for (int i = 0; i < 4; i++) begin
      bus.entradaSwitch = tabSw[i];
      bus.pedido = 1'b1;
      ciclos(2);
      check("aguardando_alto", 32'(bus.aguardando), 32'h1);
      pressionar(lat);
      check("latencia_captura", 32'(lat), 32'(LAT));
      check("dado_captura", bus.dado, tabExp[i]);
      bus.pedido = 1'b0;
      ciclos(1);
      check("pronto_largura", 32'(bus.pronto), 32'h0);
      check("aguardando_caiu", 32'(bus.aguardando), 32'h0);
      ciclos(3);
      bus.enter = 1'b1;
      ciclos(LAT + 3);
    end

    // bounce: toggle every 2 cycles, then hold low
    bus.entradaSwitch = 9'h0AA;
    bus.pedido = 1'b1;
    ciclos(2);
    cnt = 0;
    for (int s = 0; s < 10; s++) begin
      bus.enter = (s % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        @(negedge clock);
        if (bus.pronto) cnt++;
      end
    end
    pressionar(lat);
`ifdef ENTRADA_SWITCH_DEBOUNCE_EN
    check("bounce_sem_pronto", 32'(cnt), 32'h0);
    check("bounce_latencia", 32'(lat), 32'(LAT));
    check("bounce_dado", bus.dado, 32'h0000_00AA);
`endif
    bus.pedido = 1'b0;
    ciclos(3);
    bus.enter = 1'b1;
    ciclos(LAT + 3);

    // held button before pedido, then release and re-press
    bus.entradaSwitch = 9'h07F;
    bus.enter = 1'b0;
    ciclos(LAT + 4);
    bus.pedido = 1'b1;
    contarPronto(15, cnt);
    check("segurado_sem_pronto", 32'(cnt), 32'h0);
    check("segurado_aguardando", 32'(bus.aguardando), 32'h1);
    bus.enter = 1'b1;
    ciclos(LAT + 3);
    pressionar(lat);
    check("repressao_latencia", 32'(lat), 32'(LAT));
    check("repressao_dado", bus.dado, 32'h0000_007F);
    bus.pedido = 1'b0;
    ciclos(3);
    bus.enter = 1'b1;
    ciclos(LAT + 3);

    // abort: pedido dropped while waiting for a press
    bus.entradaSwitch = 9'h123;
    bus.pedido = 1'b1;
    ciclos(3);
    bus.pedido = 1'b0;
    ciclos(2);
    check("abort_aguardando", 32'(bus.aguardando), 32'h0);
    bus.enter = 1'b0;
    contarPronto(LAT + 4, cnt);
    check("abort_sem_pronto", 32'(cnt), 32'h0);
    check("abort_dado", bus.dado, 32'h0000_007F);
    bus.enter = 1'b1;
    ciclos(LAT + 3);

    // reset one cycle before the expected pronto
    bus.entradaSwitch = 9'h055;
    bus.pedido = 1'b1;
    ciclos(2);
    bus.enter = 1'b0;
    ciclos(LAT - 1);
    reset = 1'b1;
    @(negedge clock);
    check("reset_meio_pronto", 32'(bus.pronto), 32'h0);
    check("reset_meio_dado", bus.dado, 32'h0);
    reset = 1'b0;
    bus.pedido = 1'b0;
    bus.enter = 1'b1;
    contarPronto(LAT + 3, cnt);
    check("reset_meio_sem_pronto", 32'(cnt), 32'h0);
    check("reset_meio_ocioso", 32'(bus.aguardando), 32'h0);

    // back-to-back with pedido re-asserted during the release wait
    bus.entradaSwitch = 9'h011;
    bus.pedido = 1'b1;
    ciclos(2);
    pressionar(lat);
    check("b2b_latencia1", 32'(lat), 32'(LAT));
    check("b2b_dado1", bus.dado, 32'h0000_0011);
    bus.pedido = 1'b0;
    ciclos(2);
    bus.pedido = 1'b1;
    bus.entradaSwitch = 9'h122;
    contarPronto(10, cnt);
    check("b2b_sem_pronto_segurado", 32'(cnt), 32'h0);
    bus.enter = 1'b1;
    ciclos(LAT + 3);
    pressionar(lat);
    check("b2b_latencia2", 32'(lat), 32'(LAT));
    check("b2b_dado2", bus.dado, 32'hFFFF_FF22);
    bus.pedido = 1'b0;
    ciclos(3);
    bus.enter = 1'b1;
    ciclos(LAT + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
